ife_inflight_tracker: RTL and testbench
=======================================

Name: ife_inflight_tracker

Overview:
- Next-generation block tracking for the IFE parallel path; replaces the single-block, unmatched commit hookup with a DEPTH-entry in-flight table.
- Accepts blocks as they are dispatched to parallel cores and reserves those cores.
- Matches returning commit results to blocks by block ID, with a per-entry timeout.
- Retires blocks in dispatch order; failed or timed-out blocks are replayed through a valid/ready serial fallback port before they retire.

Parameters:
BLOCK_ID_WIDTH, 8, block identifier width
INSTR_WIDTH, 32, instruction width
BLOCK_SIZE, 4, instructions per block
NUM_CORES, 4, parallel cores addressable by the core mask
DEPTH, 4, in-flight table entries (power of 2, >=2)
TIMEOUT_CYCLES, 64, cycles an entry may wait for a result (>=2)

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge)
disp_valid  in  1  dispatch offer
disp_ready  out  1  table can accept
disp_block_id  in  BLOCK_ID_WIDTH  dispatched block ID
disp_block_data  in  BLOCK_SIZE*INSTR_WIDTH  block instructions, stored for replay
disp_core_mask  in  NUM_CORES  cores used by this block
res_valid  in  1  commit result strobe
res_block_id  in  BLOCK_ID_WIDTH  block the result belongs to
res_ok  in  1  1 = core results agreed, 0 = mismatch
serial_valid  out  1  replay offer
serial_ready  in  1  serial path accepts
serial_block_id  out  BLOCK_ID_WIDTH  replayed block ID
serial_block_data  out  BLOCK_SIZE*INSTR_WIDTH  replayed instructions
retire_valid  out  1  one-cycle retirement pulse
retire_block_id  out  BLOCK_ID_WIDTH  retired block ID
retire_ok  out  1  1 = parallel commit, 0 = replayed
core_reserved_mask  out  NUM_CORES  OR of core masks of all occupied entries
inflight_count  out  $clog2(DEPTH+1)  occupied entries
timeout_evt  out  1  one-cycle pulse when any entry times out
unmatched_err  out  1  sticky: a result matched no waiting entry

Behaviour:
- Storage: circular table, head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus the count.
- Entry states: FREE, WAIT, DONE_OK, DONE_FAIL.
- Reset (rst==0 at an edge): all entries FREE, pointers/count 0, retire FSM to IDLE, timers 0.
- Reset output values: all outputs 0 except disp_ready. disp_ready is 1 in the first cycle after reset deasserts and is 0 while rst==0.
- Reset mid-operation discards all entries and any pending replay without retiring them.
- disp_ready = (count < DEPTH) && rst. It does not depend on disp_valid.
- Allocation on disp_valid && disp_ready: tail entry becomes WAIT, ID/data/mask/timer=0 stored, tail++.
- Result matching: on res_valid, the oldest (head-relative) WAIT entry with an equal ID becomes DONE_OK (res_ok=1) or DONE_FAIL (res_ok=0).
  - No WAIT match (including an entry already DONE) → result ignored and unmatched_err set; it clears only on reset.
- Timeout: each WAIT timer increments every cycle. When it reaches TIMEOUT_CYCLES-1 with no result, the entry becomes DONE_FAIL on that edge and timeout_evt pulses the next cycle.
  - A matching result on the same edge as the timeout wins; no timeout_evt is raised.
- Retire FSM (registered outputs):
  - IDLE, head DONE_OK: next cycle retire_valid=1, retire_ok=1, retire_block_id=ID; entry freed, head++.
  - IDLE, head DONE_FAIL: go to REPLAY. serial_valid=1 with the entry ID/data, held stable until serial_valid && serial_ready.
  - REPLAY, handshake completes: next cycle retire pulse with retire_ok=0; entry freed, head++, back to IDLE.
  - Non-head DONE entries wait for in-order retirement.
  - At most one retirement per cycle.
- Latency: result accepted at edge t with entry at head → retire_valid high in cycle t+1, which is the minimum latency.
- Simultaneous events:
  - Allocate and free in the same cycle leaves count unchanged.
  - Dispatch into a full table is refused; a slot freed on an edge is visible as disp_ready on the next cycle.
  - A result and a dispatch with the same ID in the same cycle: the new entry is not matchable until the next cycle.
- core_reserved_mask and inflight_count are registered and reflect table contents after each edge.
- Overlapping core masks are not checked; that is the upstream dispatch unit's responsibility.

Decomposition:
- Package ife_pkg:
  - entry_state_t enum (FREE/WAIT/DONE_OK/DONE_FAIL) and retire_state_t (IDLE/REPLAY).
  - Parameterised entry struct: id, data, mask, timer, state.
  - Helper to compute the pointer width.
- One sub-module, ife_id_match: combinational oldest-first ID match over DEPTH entries, returning hit and index.

Test Plan:
- Dispatch IDs 0x10,0x11 (masks 0011,1100), results OK for 0x11 then 0x10 → retires 0x10 then 0x11, both retire_ok=1; core_reserved_mask 1111→1100→0000.
- Fill DEPTH=4 → disp_ready=0, fifth offer held. Result OK for head → one retirement, disp_ready=1 the cycle after, fifth accepted; count stays ≤4 and pointers wrap to 0.
- Result res_ok=0 for 0x20, serial_ready=0 for 3 cycles → serial_valid stable with ID 0x20 and data; on ready, retire 0x20 retire_ok=0.
- No result for 0x30 → timeout_evt after 64 cycles, then replay. Variant with the result exactly on the timeout edge → DONE_OK and no timeout_evt.
- Result for ID 0x55 not in flight → unmatched_err=1 and persists; table is unchanged.
- rst=0 during REPLAY with 3 entries → next cycle count=0, serial_valid=0, core_reserved_mask=0, no retire pulse.

Source files
------------

// File: rtl/ife_pkg.sv
// Shared types and helpers for the IFE in-flight block tracker.
package ife_pkg;

   typedef enum logic [1:0] {FREE, WAIT, DONE_OK, DONE_FAIL} entry_state_t;
   typedef enum logic {IDLE, REPLAY} retire_state_t;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ife_id_match.sv
// Oldest-first lookup of a block ID among the WAIT entries of the in-flight table.
module ife_id_match
   import ife_pkg::*;
#(
   parameter int ID_W  = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = ptr_width(DEPTH)
) (
   input  logic [DEPTH*ID_W-1:0] ids,
   input  logic [DEPTH-1:0]      waiting,
   input  logic [PTR_W-1:0]      head,
   input  logic [ID_W-1:0]       key,
   output logic                  hit,
   output logic [PTR_W-1:0]      idx
);

   logic [PTR_W-1:0] pos;

   always_comb begin
      hit = 1'b0;
      idx = '0;
      pos = '0;
      // Scan youngest to oldest so the oldest hit is the one that sticks.
      for (int k = DEPTH-1; k >= 0; k--) begin
         pos = head + PTR_W'(k);
         if (waiting[pos] && (ids[pos*ID_W +: ID_W] == key)) begin
            hit = 1'b1;
            idx = pos;
         end
      end
   end

endmodule

// File: rtl/ife_inflight_tracker.sv
// In-flight table for blocks dispatched to the parallel cores: matches commit
// results by ID, times out stragglers and retires blocks in dispatch order.
module ife_inflight_tracker
   import ife_pkg::*;
#(
   parameter int BLOCK_ID_WIDTH = 8,
   parameter int INSTR_WIDTH    = 32,
   parameter int BLOCK_SIZE     = 4,
   parameter int NUM_CORES      = 4,
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               disp_valid,
   output logic                               disp_ready,
   input  logic [BLOCK_ID_WIDTH-1:0]          disp_block_id,
   input  logic [BLOCK_SIZE*INSTR_WIDTH-1:0]  disp_block_data,
   input  logic [NUM_CORES-1:0]               disp_core_mask,
   input  logic                               res_valid,
   input  logic [BLOCK_ID_WIDTH-1:0]          res_block_id,
   input  logic                               res_ok,
   output logic                               serial_valid,
   input  logic                               serial_ready,
   output logic [BLOCK_ID_WIDTH-1:0]          serial_block_id,
   output logic [BLOCK_SIZE*INSTR_WIDTH-1:0]  serial_block_data,
   output logic                               retire_valid,
   output logic [BLOCK_ID_WIDTH-1:0]          retire_block_id,
   output logic                               retire_ok,
   output logic [NUM_CORES-1:0]               core_reserved_mask,
   output logic [$clog2(DEPTH+1)-1:0]         inflight_count,
   output logic                               timeout_evt,
   output logic                               unmatched_err
);

   localparam int PTR_W     = ptr_width(DEPTH);
   localparam int CNT_W     = $clog2(DEPTH+1);
   localparam int DATA_BITS = BLOCK_SIZE*INSTR_WIDTH;
   localparam int TMR_W     = $clog2(TIMEOUT_CYCLES);
   // An entry is given up on the edge its timer would reach TIMEOUT_CYCLES-1.
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES-2);

   typedef struct packed {
      logic [BLOCK_ID_WIDTH-1:0] id;
      logic [DATA_BITS-1:0]      data;
      logic [NUM_CORES-1:0]      mask;
      logic [TMR_W-1:0]          timer;
      entry_state_t              state;
   } entry_t;

   entry_t                       tbl   [DEPTH];
   entry_t                       tbl_n [DEPTH];
   logic [PTR_W-1:0]             head, tail;
   logic [CNT_W-1:0]             count;
   retire_state_t                rstate;
   logic                         do_alloc, do_free, tmo_any, m_hit, res_hit;
   logic [PTR_W-1:0]             m_idx;
   logic [DEPTH*BLOCK_ID_WIDTH-1:0] ids_flat;
   logic [DEPTH-1:0]             waiting;
   logic [NUM_CORES-1:0]         mask_n;

   assign disp_ready     = (count < CNT_W'(DEPTH)) && rst;
   assign inflight_count = count;
   assign do_alloc       = disp_valid && disp_ready;
   assign do_free        = ((rstate == IDLE) && (tbl[head].state == DONE_OK)) ||
                           ((rstate == REPLAY) && serial_valid && serial_ready);
   assign res_hit        = res_valid && m_hit;

   always_comb begin
      ids_flat = '0;
      waiting  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ids_flat[i*BLOCK_ID_WIDTH +: BLOCK_ID_WIDTH] = tbl[i].id;
         waiting[i] = (tbl[i].state == WAIT);
      end
   end

   ife_id_match #(.ID_W(BLOCK_ID_WIDTH), .DEPTH(DEPTH)) u_match (
      .ids     (ids_flat),
      .waiting (waiting),
      .head    (head),
      .key     (res_block_id),
      .hit     (m_hit),
      .idx     (m_idx)
   );

   always_comb begin
      tmo_any = 1'b0;
      mask_n  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         tbl_n[i] = tbl[i];
         if (tbl[i].state == WAIT) begin
            if (res_hit && (m_idx == PTR_W'(i))) begin
               tbl_n[i].state = res_ok ? DONE_OK : DONE_FAIL;
            end else if (tbl[i].timer == TMR_LAST) begin
               tbl_n[i].state = DONE_FAIL;
               tmo_any        = 1'b1;
            end else begin
               tbl_n[i].timer = tbl[i].timer + 1'b1;
            end
         end
      end
      if (do_free) tbl_n[head].state = FREE;
      if (do_alloc) begin
         tbl_n[tail].id    = disp_block_id;
         tbl_n[tail].data  = disp_block_data;
         tbl_n[tail].mask  = disp_core_mask;
         tbl_n[tail].timer = '0;
         tbl_n[tail].state = WAIT;
      end
      for (int i = 0; i < DEPTH; i++)
         if (tbl_n[i].state != FREE) mask_n = mask_n | tbl_n[i].mask;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl[i].state <= FREE;
            tbl[i].timer <= '0;
         end
         head               <= '0;
         tail               <= '0;
         count              <= '0;
         core_reserved_mask <= '0;
         timeout_evt        <= 1'b0;
         unmatched_err      <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) tbl[i] <= tbl_n[i];
         head               <= head + PTR_W'(do_free);
         tail               <= tail + PTR_W'(do_alloc);
         count              <= count + CNT_W'(do_alloc) - CNT_W'(do_free);
         core_reserved_mask <= mask_n;
         timeout_evt        <= tmo_any;
         if (res_valid && !m_hit) unmatched_err <= 1'b1;
      end
   end

   // Retire FSM: in-order retirement, failed heads detour through the serial port.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rstate            <= IDLE;
         retire_valid      <= 1'b0;
         retire_ok         <= 1'b0;
         retire_block_id   <= '0;
         serial_valid      <= 1'b0;
         serial_block_id   <= '0;
         serial_block_data <= '0;
      end else begin
         retire_valid <= 1'b0;
         case (rstate)
            IDLE: begin
               if (tbl[head].state == DONE_OK) begin
                  retire_valid    <= 1'b1;
                  retire_ok       <= 1'b1;
                  retire_block_id <= tbl[head].id;
               end else if (tbl[head].state == DONE_FAIL) begin
                  rstate            <= REPLAY;
                  serial_valid      <= 1'b1;
                  serial_block_id   <= tbl[head].id;
                  serial_block_data <= tbl[head].data;
               end
            end
            REPLAY: begin
               if (serial_ready) begin
                  rstate          <= IDLE;
                  serial_valid    <= 1'b0;
                  retire_valid    <= 1'b1;
                  retire_ok       <= 1'b0;
                  retire_block_id <= serial_block_id;
               end
            end
            default: rstate <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ife_inflight_tracker.sv
// Directed bench for ife_inflight_tracker: queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_ife_inflight_tracker;

   localparam int IDW   = 8;
   localparam int DW    = 128;
   localparam int NC    = 4;
   localparam int DEPTH = 4;
   localparam int TMO   = 64;
   localparam int S_WAIT = 0, S_OK = 1, S_FAIL = 2;

   logic           clk, rst;
   logic           disp_valid, disp_ready;
   logic [IDW-1:0] disp_block_id;
   logic [DW-1:0]  disp_block_data;
   logic [NC-1:0]  disp_core_mask;
   logic           res_valid, res_ok;
   logic [IDW-1:0] res_block_id;
   logic           serial_valid, serial_ready;
   logic [IDW-1:0] serial_block_id;
   logic [DW-1:0]  serial_block_data;
   logic           retire_valid, retire_ok;
   logic [IDW-1:0] retire_block_id;
   logic [NC-1:0]  core_reserved_mask;
   logic [2:0]     inflight_count;
   logic           timeout_evt, unmatched_err;

   ife_inflight_tracker #(
      .BLOCK_ID_WIDTH(IDW), .INSTR_WIDTH(32), .BLOCK_SIZE(4),
      .NUM_CORES(NC), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_block_id(disp_block_id), .disp_block_data(disp_block_data),
      .disp_core_mask(disp_core_mask),
      .res_valid(res_valid), .res_block_id(res_block_id), .res_ok(res_ok),
      .serial_valid(serial_valid), .serial_ready(serial_ready),
      .serial_block_id(serial_block_id), .serial_block_data(serial_block_data),
      .retire_valid(retire_valid), .retire_block_id(retire_block_id),
      .retire_ok(retire_ok), .core_reserved_mask(core_reserved_mask),
      .inflight_count(inflight_count), .timeout_evt(timeout_evt),
      .unmatched_err(unmatched_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: blocks in dispatch order, each remembering the edge it arrived on.
   typedef struct {
      logic [IDW-1:0] id;
      logic [DW-1:0]  data;
      logic [NC-1:0]  mask;
      int             st;
      int             t0;
   } ent_t;

   ent_t           q[$];
   int             cyc = 0;
   bit             m_valid = 0, rep, m_pop, m_full;
   int             m_hit;
   logic           m_rv, m_rok, m_sv, m_tmo, m_unm;
   logic [IDW-1:0] m_rid, m_sid;
   logic [DW-1:0]  m_sdata;
   logic [NC-1:0]  exp_mask;

   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         q.delete();
         rep = 0; m_rv = 0; m_rok = 0; m_rid = '0; m_sv = 0; m_sid = '0;
         m_sdata = '0; m_tmo = 0; m_unm = 0; m_valid = 1;
      end else begin
         m_full = (q.size() >= DEPTH);
         m_pop  = 0;
         m_rv   = 0;
         m_tmo  = 0;
         if (rep) begin
            if (m_sv && serial_ready) begin
               m_rv = 1; m_rid = q[0].id; m_rok = 0; m_sv = 0; rep = 0; m_pop = 1;
            end
         end else if (q.size() > 0 && q[0].st == S_OK) begin
            m_rv = 1; m_rid = q[0].id; m_rok = 1; m_pop = 1;
         end else if (q.size() > 0 && q[0].st == S_FAIL) begin
            rep = 1; m_sv = 1; m_sid = q[0].id; m_sdata = q[0].data;
         end
         if (res_valid) begin
            m_hit = -1;
            for (int i = 0; i < q.size(); i++)
               if (m_hit < 0 && q[i].st == S_WAIT && q[i].id == res_block_id) m_hit = i;
            if (m_hit < 0) m_unm = 1;
            else q[m_hit].st = res_ok ? S_OK : S_FAIL;
         end
         for (int i = 0; i < q.size(); i++)
            if (q[i].st == S_WAIT && (cyc - q[i].t0) == TMO-1) begin
               q[i].st = S_FAIL;
               m_tmo = 1;
            end
         if (m_pop) void'(q.pop_front());
         if (disp_valid && !m_full)
            q.push_back('{disp_block_id, disp_block_data, disp_core_mask, S_WAIT, cyc});
      end
   end

   always @(posedge clk) begin
      #2;
      if (m_valid) begin
         exp_mask = '0;
         foreach (q[i]) exp_mask = exp_mask | q[i].mask;
         chk("disp_ready",   disp_ready,   rst && (q.size() < DEPTH));
         chk("count",        inflight_count, q.size());
         chk("core_mask",    core_reserved_mask, exp_mask);
         chk("retire_valid", retire_valid, m_rv);
         chk("retire_id",    retire_block_id, m_rid);
         chk("retire_ok",    retire_ok,    m_rok);
         chk("serial_valid", serial_valid, m_sv);
         chk("serial_id",    serial_block_id, m_sid);
         chk("serial_data",  serial_block_data, m_sdata);
         chk("timeout_evt",  timeout_evt,  m_tmo);
         chk("unmatched",    unmatched_err, m_unm);
      end
   end

   task automatic dispatch(input logic [IDW-1:0] id, input logic [DW-1:0] data, input logic [NC-1:0] mask);
      int k = 0;
      while (!disp_ready && k < 200) begin @(negedge clk); k++; end
      disp_valid = 1; disp_block_id = id; disp_block_data = data; disp_core_mask = mask;
      @(negedge clk);
      disp_valid = 0;
   endtask

   task automatic result(input logic [IDW-1:0] id, input logic ok);
      res_valid = 1; res_block_id = id; res_ok = ok;
      @(negedge clk);
      res_valid = 0;
   endtask

   task automatic expect_retire(input logic [IDW-1:0] id, input logic ok);
      int k = 0;
      @(negedge clk);
      while (!retire_valid && k < 200) begin @(negedge clk); k++; end
      chk("retire_seen", retire_valid, 1'b1);
      if (retire_valid) begin
         chk("lit_retire_id", retire_block_id, id);
         chk("lit_retire_ok", retire_ok, ok);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: bench did not finish, n_cmp=%0d", n_cmp);
      $fatal(1);
   end

   initial begin
      int k;
      logic saw;
      rst = 0; disp_valid = 0; disp_block_id = '0; disp_block_data = '0; disp_core_mask = '0;
      res_valid = 0; res_block_id = '0; res_ok = 0; serial_ready = 0;
      repeat (2) @(negedge clk);
      chk("lit_rst_ready", disp_ready, 1'b0);
      chk("lit_rst_count", inflight_count, 3'd0);
      rst = 1;
      @(negedge clk);
      chk("lit_ready_after_rst", disp_ready, 1'b1);

      // Out-of-order results, in-order retirement
      dispatch(8'h10, 128'h1010, 4'b0011);
      dispatch(8'h11, 128'h1111, 4'b1100);
      chk("lit_mask_1111", core_reserved_mask, 4'b1111);
      result(8'h11, 1);
      result(8'h10, 1);
      expect_retire(8'h10, 1);
      chk("lit_mask_1100", core_reserved_mask, 4'b1100);
      expect_retire(8'h11, 1);
      chk("lit_mask_0000", core_reserved_mask, 4'b0000);

      // Full table, held fifth offer, pointer wrap
      for (int i = 0; i < 4; i++) dispatch(8'h40 + 8'(i), 128'(i), 4'b0001);
      chk("lit_full_ready", disp_ready, 1'b0);
      chk("lit_full_count", inflight_count, 3'd4);
      disp_valid = 1; disp_block_id = 8'h44; disp_block_data = 128'h44; disp_core_mask = 4'b0010;
      repeat (2) @(negedge clk);
      chk("lit_held_count", inflight_count, 3'd4);
      result(8'h40, 1);
      @(negedge clk);
      chk("lit_free_retire", retire_block_id, 8'h40);
      chk("lit_free_ready", disp_ready, 1'b1);
      @(negedge clk);
      disp_valid = 0;
      chk("lit_refill_count", inflight_count, 3'd4);
      for (int i = 1; i < 5; i++) begin
         result(8'h40 + 8'(i), 1);
         expect_retire(8'h40 + 8'(i), 1);
      end

      // Mismatch result, serial port back-pressure
      dispatch(8'h20, 128'hDEADBEEF_0BADF00D_12345678_9ABCDEF0, 4'b0101);
      result(8'h20, 0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("lit_sv_hold", serial_valid, 1'b1);
         chk("lit_sid_hold", serial_block_id, 8'h20);
         chk("lit_sdata_hold", serial_block_data, 128'hDEADBEEF_0BADF00D_12345678_9ABCDEF0);
         @(negedge clk);
      end
      serial_ready = 1;
      @(negedge clk);
      serial_ready = 0;
      chk("lit_replay_rv", retire_valid, 1'b1);
      chk("lit_replay_id", retire_block_id, 8'h20);
      chk("lit_replay_ok", retire_ok, 1'b0);

      // Timeout, then replay
      dispatch(8'h30, 128'h30, 4'b1000);
      k = 1;
      while (!timeout_evt && k < 200) begin @(negedge clk); k++; end
      chk("lit_tmo_latency", k, 64);
      serial_ready = 1;
      expect_retire(8'h30, 0);
      serial_ready = 0;

      // Result on the timeout edge wins
      dispatch(8'h31, 128'h31, 4'b1000);
      repeat (62) @(negedge clk);
      result(8'h31, 1);
      saw = timeout_evt;
      chk("lit_no_tmo", saw, 1'b0);
      expect_retire(8'h31, 1);

      // Unmatched result
      dispatch(8'h56, 128'h56, 4'b0001);
      result(8'h55, 1);
      chk("lit_unmatched", unmatched_err, 1'b1);
      chk("lit_unm_count", inflight_count, 3'd1);
      result(8'h56, 1);
      expect_retire(8'h56, 1);
      repeat (3) @(negedge clk);
      chk("lit_unm_sticky", unmatched_err, 1'b1);

      // Reset during replay
      dispatch(8'h60, 128'h60, 4'b0001);
      dispatch(8'h61, 128'h61, 4'b0010);
      dispatch(8'h62, 128'h62, 4'b0100);
      result(8'h60, 0);
      @(negedge clk);
      chk("lit_pre_rst_sv", serial_valid, 1'b1);
      chk("lit_pre_rst_cnt", inflight_count, 3'd3);
      rst = 0;
      @(negedge clk);
      chk("lit_rst_cnt", inflight_count, 3'd0);
      chk("lit_rst_sv", serial_valid, 1'b0);
      chk("lit_rst_mask", core_reserved_mask, 4'b0000);
      chk("lit_rst_rv", retire_valid, 1'b0);
      chk("lit_rst_unm", unmatched_err, 1'b0);
      chk("lit_rst_ready0", disp_ready, 1'b0);
      rst = 1;
      @(negedge clk);
      chk("lit_rst_ready1", disp_ready, 1'b1);
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
